// File: rtl/sad_search_ctrl_if.sv
// Bus bundle between the block-fetch side, the SAD unit and the full-search
// scheduler. The scheduler takes the slave view; the environment drives the
// master view.
interface sad_search_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int MVW    = 4
);
    logic                start;
    logic                ref_rdy;
    logic [MVW-1:0]      cand_dx;
    logic [MVW-1:0]      cand_dy;
    logic                cal_en;
    logic [8+DWIDTH-1:0] sad;
    logic                sad_vld;
    logic                busy;
    logic                done;
    logic [8+DWIDTH-1:0] best_sad;
    logic [MVW-1:0]      best_mvx;
    logic [MVW-1:0]      best_mvy;

    modport slave (
        input  start, ref_rdy, sad, sad_vld,
        output cand_dx, cand_dy, cal_en, busy, done, best_sad, best_mvx, best_mvy
    );

    modport master (
        output start, ref_rdy, sad, sad_vld,
        input  cand_dx, cand_dy, cal_en, busy, done, best_sad, best_mvx, best_mvy
    );
endinterface

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation scheduler. Issues every (dx,dy) in
// [-SR,+SR]^2 in raster order to the SAD unit, one per ready cycle, and
// tracks the minimum returned SAD together with its motion vector.
module sad_search_ctrl #(
    parameter int DWIDTH  = 8,
    parameter int SR      = 2,
    parameter int SAD_LAT = 6,
    parameter int MVW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    sad_search_ctrl_if.slave bus
);
    localparam int unsigned SW    = 8 + DWIDTH;
    localparam int unsigned NCAND = (2*SR+1) * (2*SR+1);
    localparam int unsigned CW    = $clog2(NCAND + 1);

    localparam logic signed [MVW-1:0] POS      = MVW'(SR);
    localparam logic signed [MVW-1:0] NEG      = MVW'(-SR);
    localparam logic signed [MVW-1:0] ONE      = MVW'(1);
    localparam logic        [CW-1:0]  CNT_FULL = CW'(NCAND);
    localparam logic        [CW-1:0]  CNT_LAST = CW'(NCAND - 1);
    localparam logic        [CW-1:0]  CNT_ONE  = CW'(1);

    // A zero-latency SAD unit would close a combinational path from cal_en
    // back into sad_vld, and the offsets must fit in MVW signed bits.
    generate
        if (SAD_LAT < 1) begin : g_lat_chk
            $error("sad_search_ctrl: SAD_LAT must be at least 1");
        end
        if (SR < 0 || SR >= (1 << (MVW - 1))) begin : g_sr_chk
            $error("sad_search_ctrl: MVW too narrow for SR");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;

    logic signed [MVW-1:0] cand_dx, cand_dy;
    logic signed [MVW-1:0] ret_x, ret_y;
    logic        [CW-1:0]  ret_cnt;
    logic        [SW-1:0]  best_sad;
    logic signed [MVW-1:0] best_mvx, best_mvy;

    logic cal_en;
    logic issue_last;
    logic count_vld;
    logic ret_full;

    assign issue_last = (cand_dx == POS) && (cand_dy == POS);
    assign count_vld  = bus.sad_vld && ((state == ISSUE) || (state == DRAIN))
                        && (ret_cnt != CNT_FULL);
    // The final return completes the search in the same cycle it arrives,
    // so DONE follows directly without an extra DRAIN cycle.
    assign ret_full   = (ret_cnt == CNT_FULL) || (count_vld && (ret_cnt == CNT_LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and the combinational issue strobe.
    always_comb begin
        state_n = state;
        cal_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cal_en = bus.ref_rdy;
                if (bus.ref_rdy && issue_last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_full) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Candidate issue position, return position counters and best tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_dx  <= NEG;
            cand_dy  <= NEG;
            ret_x    <= NEG;
            ret_y    <= NEG;
            ret_cnt  <= '0;
            best_sad <= '0;
            best_mvx <= '0;
            best_mvy <= '0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                cand_dx  <= NEG;
                cand_dy  <= NEG;
                ret_x    <= NEG;
                ret_y    <= NEG;
                ret_cnt  <= '0;
                best_sad <= '1;
                best_mvx <= '0;
                best_mvy <= '0;
            end

            // The last candidate leaves the position parked at (+SR,+SR).
            if (cal_en && !issue_last) begin
                if (cand_dx == POS) begin
                    cand_dx <= NEG;
                    cand_dy <= cand_dy + ONE;
                end else begin
                    cand_dx <= cand_dx + ONE;
                end
            end

            if (count_vld) begin
                ret_cnt <= ret_cnt + CNT_ONE;
                if (ret_x == POS) begin
                    ret_x <= NEG;
                    ret_y <= ret_y + ONE;
                end else begin
                    ret_x <= ret_x + ONE;
                end
                if (bus.sad < best_sad) begin
                    best_sad <= bus.sad;
                    best_mvx <= ret_x;
                    best_mvy <= ret_y;
                end
            end
        end
    end

    assign bus.cal_en   = cal_en;
    assign bus.cand_dx  = cand_dx;
    assign bus.cand_dy  = cand_dy;
    assign bus.busy     = (state == ISSUE) || (state == DRAIN);
    assign bus.done     = (state == DONE);
    assign bus.best_sad = best_sad;
    assign bus.best_mvx = best_mvx;
    assign bus.best_mvy = best_mvy;
endmodule
